// File: rtl/mc_controller.sv
// mc_controller - multi-cycle control FSM for the MIPS-subset data_path.
//
// Decodes opcode/func, sequences one instruction phase per clock and drives
// every datapath control strobe. Outputs are a Moore decode of the state
// register, except branch pc_write, which is qualified by ZERO.
//
// Optional feature (macro MEM_WAIT_EN): adds input mem_ready. FETCH, MEM_READ
// and MEM_WRITE then hold until mem_ready=1. The completion strobes (IRwrite,
// pc_write, instr_done) fire only in the cycle where mem_ready=1.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   opcode, func    IR[31:26], IR[5:0] from the datapath
//   ZERO            ALU zero flag
//   mem_ready       memory handshake (MEM_WAIT_EN builds only)
//   pc_write, IRwrite, reg_dst, jal_rej, pc_to_reg, mem_to_reg, reg_write,
//   AluSrcA, AluSrcB[3:0] (one-hot), AluOp[2:0], pc_src[2:0], IorD,
//   mem_write, mem_read, instr_done   datapath control outputs
module mc_controller #(
  parameter int unsigned STATE_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       ZERO,
`ifdef MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       pc_write,
  output logic       IRwrite,
  output logic       reg_dst,
  output logic       jal_rej,
  output logic       pc_to_reg,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       AluSrcA,
  output logic [3:0] AluSrcB,
  output logic [2:0] AluOp,
  output logic [2:0] pc_src,
  output logic       IorD,
  output logic       mem_write,
  output logic       mem_read,
  output logic       instr_done
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC,
    R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL, JR
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       IRwrite;
    logic       reg_dst;
    logic       jal_rej;
    logic       pc_to_reg;
    logic       mem_to_reg;
    logic       reg_write;
    logic       AluSrcA;
    logic [3:0] AluSrcB;
    logic [2:0] AluOp;
    logic [2:0] pc_src;
    logic       IorD;
    logic       mem_write;
    logic       mem_read;
    logic       instr_done;
  } ctl_t;

  state_t     r_state;
  state_t     w_next;
  ctl_t       w_ctl;
  logic       w_rdy;
  // opcode is only looked at in DECODE/MEM_ADDR, so the details needed later
  // (branch sense, I-type ALU op) are captured while in DECODE.
  logic       r_is_bne;
  logic [2:0] r_iop;

`ifdef MEM_WAIT_EN
  assign w_rdy = mem_ready;
`else
  assign w_rdy = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= FETCH;
      r_is_bne <= 1'b0;
      r_iop    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) begin
        r_is_bne <= (opcode == OP_BNE);
        case (opcode)
          OP_ANDI: r_iop <= 3'd3;
          OP_SLTI: r_iop <= 3'd4;
          default: r_iop <= 3'd0;
        endcase
      end
    end
  end

  always_comb begin
    w_ctl  = '0;
    w_next = FETCH;
    case (r_state)
      FETCH: begin
        w_ctl.mem_read = 1'b1;
        w_ctl.IRwrite  = w_rdy;
        w_ctl.AluSrcB  = 4'b0010;
        w_ctl.pc_write = w_rdy;
        w_next         = w_rdy ? DECODE : FETCH;
      end
      DECODE: begin
        w_ctl.AluSrcB = 4'b1000;
        case (opcode)
          OP_R:                      w_next = (func == FN_JR) ? JR : R_EXEC;
          OP_LW, OP_SW:              w_next = MEM_ADDR;
          OP_BEQ, OP_BNE:            w_next = BRANCH;
          OP_J:                      w_next = JUMP;
          OP_JAL:                    w_next = JAL;
          OP_ADDI, OP_ANDI, OP_SLTI: w_next = I_EXEC;
          default:                   w_next = FETCH;
        endcase
      end
      MEM_ADDR: begin
        w_ctl.AluSrcA = 1'b1;
        w_ctl.AluSrcB = 4'b0100;
        w_next        = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        w_ctl.mem_read = 1'b1;
        w_ctl.IorD     = 1'b1;
        w_next         = w_rdy ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.mem_to_reg = 1'b1;
        w_ctl.instr_done = 1'b1;
      end
      MEM_WRITE: begin
        w_ctl.mem_write  = 1'b1;
        w_ctl.IorD       = 1'b1;
        w_ctl.instr_done = w_rdy;
        w_next           = w_rdy ? FETCH : MEM_WRITE;
      end
      R_EXEC: begin
        w_ctl.AluSrcA = 1'b1;
        w_ctl.AluSrcB = 4'b0001;
        w_ctl.AluOp   = 3'd2;
        w_next        = R_WB;
      end
      R_WB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.reg_dst    = 1'b1;
        w_ctl.instr_done = 1'b1;
      end
      I_EXEC: begin
        w_ctl.AluSrcA = 1'b1;
        w_ctl.AluSrcB = 4'b0100;
        w_ctl.AluOp   = r_iop;
        w_next        = I_WB;
      end
      I_WB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.instr_done = 1'b1;
      end
      BRANCH: begin
        w_ctl.AluSrcA    = 1'b1;
        w_ctl.AluSrcB    = 4'b0001;
        w_ctl.AluOp      = 3'd1;
        w_ctl.pc_src     = 3'd1;
        w_ctl.pc_write   = ZERO ^ r_is_bne;
        w_ctl.instr_done = 1'b1;
      end
      JUMP: begin
        w_ctl.pc_src     = 3'd2;
        w_ctl.pc_write   = 1'b1;
        w_ctl.instr_done = 1'b1;
      end
      JAL: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.jal_rej    = 1'b1;
        w_ctl.pc_to_reg  = 1'b1;
        w_ctl.pc_src     = 3'd2;
        w_ctl.pc_write   = 1'b1;
        w_ctl.instr_done = 1'b1;
      end
      JR: begin
        w_ctl.pc_src     = 3'd3;
        w_ctl.pc_write   = 1'b1;
        w_ctl.instr_done = 1'b1;
      end
      default: w_next = FETCH;
    endcase
  end

  // Reset masks every strobe combinationally so an aborted instruction
  // cannot write in the reset cycle.
  assign {pc_write, IRwrite, reg_dst, jal_rej, pc_to_reg, mem_to_reg,
          reg_write, AluSrcA, AluSrcB, AluOp, pc_src, IorD, mem_write,
          mem_read, instr_done} = rst ? '0 : w_ctl;

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle control FSM for the MIPS-subset `data_path`.
- Consumes `opcode`, `func` and `ZERO` from the datapath; drives every datapath control strobe, one instruction phase per clock.
- Moore machine: outputs decode from the state register only, except branch `pc_write`, which is gated by `ZERO`.
- Sits beside `data_path` in the CPU top level.

Parameters:
- STATE_W, 4, width of the state register (14 states used).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  6  IR[31:26] from datapath.
- func  input  6  IR[5:0] from datapath.
- ZERO  input  1  ALU zero flag.
- pc_write  output  1  PC load enable.
- IRwrite  output  1  IR load enable.
- reg_dst  output  1  0=rt, 1=rd write address.
- jal_rej  output  1  1=force write address 31.
- pc_to_reg  output  1  1=write PC to the register file.
- mem_to_reg  output  1  0=AluOut, 1=MDR.
- reg_write  output  1  register file write enable.
- AluSrcA  output  1  0=PC, 1=A.
- AluSrcB  output  4  one-hot: 0001=B, 0010=const 4, 0100=sext(imm), 1000=sext(imm)<<2.
- AluOp  output  3  0=add, 1=sub, 2=R-type (func decode), 3=and, 4=slt.
- pc_src  output  3  0=ALU result, 1=AluOut, 2=jump address, 3=A register.
- IorD  output  1  0=PC address, 1=AluOut address.
- mem_write  output  1  memory write strobe.
- mem_read  output  1  memory read strobe.
- instr_done  output  1  one-cycle pulse in the final state of each instruction.

Behaviour:
- Reset:
  - rst=1 at a rising edge: state<=FETCH.
  - While rst=1, all outputs are forced to 0. AluSrcB=0000 is legal only in reset.
- Default outputs in every state are 0 (AluSrcB=0000) unless listed below.
- Supported opcodes:
  - R=000000; jr is R with func=001000.
  - lw=100011, sw=101011, beq=000100, bne=000101, j=000010, jal=000011, addi=001000, andi=001100, slti=001010.
- FETCH: mem_read=1, IorD=0, IRwrite=1, AluSrcA=0, AluSrcB=0010, AluOp=0, pc_src=0, pc_write=1 -> DECODE.
- DECODE: AluSrcA=0, AluSrcB=1000, AluOp=0 (branch target into AluOut). Next state by opcode:
  - lw/sw -> MEM_ADDR.
  - R with func=001000 -> JR; other R -> R_EXEC.
  - beq/bne -> BRANCH.
  - j -> JUMP; jal -> JAL.
  - addi/andi/slti -> I_EXEC.
  - Any other opcode -> FETCH, no side effects (NOP).
- MEM_ADDR: AluSrcA=1, AluSrcB=0100, AluOp=0 -> MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_read=1, IorD=1 -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1 -> FETCH.
- MEM_WRITE: mem_write=1, IorD=1, instr_done=1 -> FETCH.
- R_EXEC: AluSrcA=1, AluSrcB=0001, AluOp=2 -> R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
- I_EXEC: AluSrcA=1, AluSrcB=0100, AluOp = 0 (addi), 3 (andi) or 4 (slti) -> I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 -> FETCH.
- BRANCH:
  - AluSrcA=1, AluSrcB=0001, AluOp=1, pc_src=1.
  - pc_write = ZERO for beq, ~ZERO for bne.
  - instr_done=1 -> FETCH.
- JUMP: pc_src=2, pc_write=1, instr_done=1 -> FETCH.
- JAL: reg_write=1, jal_rej=1, pc_to_reg=1 (PC already holds PC+4), pc_src=2, pc_write=1, instr_done=1 -> FETCH.
- JR: pc_src=3, pc_write=1, instr_done=1 -> FETCH.
- Cycle counts, FETCH inclusive:
  - lw 5.
  - sw, R, I-type 4.
  - beq/bne, j, jal, jr 3.
  - Illegal opcode 2.
- Unused state encodings -> FETCH on the next edge, all outputs 0.
- rst asserted mid-instruction aborts it: no write strobe in the reset cycle, FETCH follows.
- opcode/func are sampled only in DECODE and MEM_ADDR. ZERO is used only in BRANCH.

Optional Feature:
- Macro: MEM_WAIT_EN.
- Defined: adds input `mem_ready` (1 bit). FETCH, MEM_READ and MEM_WRITE hold their state while mem_ready=0:
  - mem_read/mem_write and IorD stay asserted.
  - IRwrite, pc_write and instr_done are asserted only in the cycle mem_ready=1.
  - The state advances on the edge where mem_ready=1.
- Undefined: no `mem_ready` port; memory is assumed single-cycle; timing exactly as above.

Test Plan:
- Reset, then R add (000000/100000): states FETCH, DECODE, R_EXEC, R_WB, FETCH.
  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1.
- lw then sw:
  - lw takes 5 cycles; MEM_READ has IorD=1, mem_read=1; MEM_WB has mem_to_reg=1.
  - sw takes 4 cycles; mem_write=1 for exactly 1 cycle.
- beq with ZERO=1 -> pc_write=1, pc_src=1 in BRANCH.
  - beq with ZERO=0 -> pc_write=0.
  - bne with ZERO=0 -> pc_write=1.
- jal -> 3 cycles; JAL state: jal_rej=1, pc_to_reg=1, reg_write=1, pc_src=2.
  - jr (func=001000) -> pc_src=3, pc_write=1.
- Illegal opcode 111111 -> DECODE then FETCH with no write strobes.
  - rst pulsed during MEM_READ -> all outputs 0, then FETCH.
- MEM_WAIT_EN defined: mem_ready=0 for 3 cycles in FETCH -> IRwrite and pc_write stay 0 and mem_read stays 1 for those 3 cycles; both assert once, with mem_ready=1.
